// File: rtl/sumador_serie_ctrl.sv
// Serial wide adder/subtractor: sequences one 4-bit adder slice over NIBBLES cycles,
// least-significant nibble first, with the carry held in a register between nibbles.
module sumador_serie_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   carry_out,
  output logic                   overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The shared 4-bit adder slice: {carry, sum[3:0]}.
  function automatic logic [4:0] add4(input logic [3:0] x, input logic [3:0] y, input logic cin);
    return {1'b0, x} + {1'b0, y} + {4'b0000, cin};
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            c_r;
  logic [IW-1:0]   idx_r;
  logic [W-1:0]    sum_r;
  logic            co_r;
  logic            ov_r;
  logic            busy_r;
  logic            done_r;

  logic [W-1:0]    a_shift_s;
  logic [W-1:0]    b_shift_s;
  logic [4:0]      slice_s;
  logic            last_s;
  logic [W-1:0]    sum_upd_s;
  logic [W+1:0]    shamt_s;

  // Slice operand selection and merge of the slice result into the running sum.
  always_comb begin
    shamt_s   = (W+2)'({idx_r, 2'b00});
    a_shift_s = a_r >> shamt_s;
    b_shift_s = b_r >> shamt_s;
    slice_s   = add4(a_shift_s[3:0], b_shift_s[3:0], c_r);
    last_s    = (idx_r == IW'(NIBBLES - 1));
    sum_upd_s = (sum_r & ~(W'(4'hF) << shamt_s)) | (W'(slice_s[3:0]) << shamt_s);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand capture on acceptance, then one nibble per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= {W{1'b0}};
      b_r   <= {W{1'b0}};
      c_r   <= 1'b0;
      idx_r <= {IW{1'b0}};
      sum_r <= {W{1'b0}};
      co_r  <= 1'b0;
      ov_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            c_r   <= sub;
            idx_r <= {IW{1'b0}};
            sum_r <= {W{1'b0}};
            co_r  <= 1'b0;
            ov_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          sum_r <= sum_upd_s;
          c_r   <= slice_s[4];
          idx_r <= idx_r + IW'(1);
          // Signed overflow: operands agree in sign but the top result bit does not.
          if (last_s) begin
            co_r <= slice_s[4];
            ov_r <= (a_r[W-1] == b_r[W-1]) && (slice_s[3] != a_r[W-1]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign sum       = sum_r;
  assign carry_out = co_r;
  assign overflow  = ov_r;

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Scoreboard bench for sumador_serie_ctrl (NIBBLES=4): directed operations push
// expected results; a negedge monitor pops and checks them whenever done is high.
module tb_sumador_serie_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   k;

  sumador_serie_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done cycle consumes exactly one expected result.
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("sum", {16'h0000, sum}, {16'h0000, e.s});
          chk("carry_out", {31'd0, carry_out}, {31'd0, e.co});
          chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
        end
        if (prev_done) chk("done_width", 32'd2, 32'd1);
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                       input logic [15:0] es, input logic eco, input logic eov);
    exp_t e;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; sub = ts;
    k = cyc + 1;
    e.s = es; e.co = eco; e.ov = eov; e.due = k + 4;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = ~ts;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    repeat (6) @(negedge clk);
    chk("sum_held", {16'h0000, sum}, {16'h0000, es});
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {16'h0000, sum}, 32'd0);
    chk("rst_co", {31'd0, carry_out}, 32'd0);
    chk("rst_ov", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    issue(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    issue(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    issue(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

    // start pulses during RUN and DONE must be ignored
    @(negedge clk);
    start = 1'b1; a = 16'h0101; b = 16'h0202; sub = 1'b0;
    k = cyc + 1;
    e.s = 16'h0303; e.co = 1'b0; e.ov = 1'b0; e.due = k + 4;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'hAAAA; b = 16'hAAAA;
    @(negedge clk);
    start = 1'b0;
    chk("busy_run_ignore", {31'd0, busy}, 32'd1);
    while (cyc < k + 4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_done_ignore", {31'd0, busy}, 32'd0);
    repeat (8) @(negedge clk);
    chk("ignore_sum_held", {16'h0000, sum}, 32'h0303);

    // reset mid-RUN after two nibbles
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun_busy", {31'd0, busy}, 32'd1);
    chk("midrun_partial", {16'h0000, sum}, 32'h00FE);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", {16'h0000, sum}, 32'd0);
    chk("abort_co", {31'd0, carry_out}, 32'd0);
    chk("abort_ov", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // start held high: one op every 6 cycles
    @(negedge clk);
    start = 1'b1; a = 16'h0001; b = 16'h0001; sub = 1'b0;
    k = cyc + 1;
    for (int n = 0; n < 4; n++) begin
      e.s = 16'h0002; e.co = 1'b0; e.ov = 1'b0; e.due = k + 4 + 6 * n;
      q.push_back(e);
    end
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    chk("pending_ops", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sumador_serie_ctrl.md
# sumador_serie_ctrl

Controller that sequences a single 4-bit adder slice (the team's existing 4-bit adder with carry-in and carry-out) over several cycles. It performs wide add or subtract operations one nibble at a time, least-significant nibble first. The carry is kept in a register between nibbles. It sits between a requester using a start/done handshake and the shared 4-bit adder datapath, giving wide arithmetic without a wide adder.

## Interface
- NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal range 2..8)

- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new operation; sampled only in IDLE
- sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  W  operand A; sampled with start
- b  input  W  operand B; sampled with start
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle pulse, result valid
- sum  output  W  result, held until next accepted start
- carry_out  output  1  final carry (for sub: 1 = no borrow)
- overflow  output  1  two's-complement signed overflow

## Operation
- Reset: the following are forced to 0 asynchronously while rst_n is low: state=IDLE, busy, done, sum, carry_out, overflow, nibble index, carry register, and operand registers.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start=1.
  - Latch A_r=a.
  - Latch B_r = sub ? ~b : b.
  - Set carry register C = sub.
  - Set index i=0 and clear the sum register.
- RUN, each cycle:
  - Adder slice gets A_r[4i+3:4i], B_r[4i+3:4i], c_in=C.
  - On the edge, the slice sum is written to sum[4i+3:4i], C takes the slice carry, and i increments.
  - RUN → DONE on the edge that processes i=NIBBLES−1.
  - On that same edge:
    - carry_out = slice carry.
    - overflow = (A_r[W−1]==B_r[W−1]) && (slice sum bit 3 != A_r[W−1]).
- DONE: done=1 for exactly one cycle, then → IDLE unconditionally.
- start in RUN or DONE is ignored, with no queuing; operand inputs are don't-care outside IDLE.
- sum, carry_out and overflow are stable from DONE until the next accepted start. On the acceptance edge the sum register clears to 0, and carry_out/overflow clear to 0.
- Arithmetic is modulo 2^W; no saturation.
- Subtract uses invert-and-carry-in-1. Example: 0 − 0 gives carry_out=1.

## Timing
- Latency: start sampled high at edge k. RUN occupies edges k+1..k+NIBBLES. done is high during the cycle after edge k+NIBBLES.
  - For NIBBLES=4, done is high between edges k+4 and k+5.
- Throughput: one operation per NIBBLES+2 cycles when start is held high continuously.
- busy rises after edge k and falls with done (after edge k+NIBBLES+1).
- done never asserts without a preceding accepted start; it is never high two cycles in a row.
- Reset during RUN/DONE aborts immediately, with no done pulse. After release, the first edge with start=1 is accepted.
- rst_n deassertion is assumed synchronous to clk externally; no internal synchronizer.

## Test plan
NIBBLES=4.
- Add 0xFFFF+0x0001 → sum=0x0000, carry_out=1, overflow=0. done exactly 4 edges after start edge, width 1 cycle.
- Add 0x7FFF+0x0001 → sum=0x8000, carry_out=0, overflow=1. Add 0x1234+0x4321 → sum=0x5555, carry_out=0, overflow=0.
- Sub 0x0005−0x0007 → sum=0xFFFE, carry_out=0, overflow=0. Sub 0x8000−0x0001 → sum=0x7FFF, carry_out=1, overflow=1.
- Pulse start again (a=0xAAAA) during RUN and during DONE of an operation on 0x0101+0x0202.
  - Result 0x0303 is unaffected.
  - Only one done pulse.
  - busy stays high.
- Assert rst_n=0 mid-RUN (after 2 nibbles of 0xFFFF+0xFFFF).
  - All outputs go to 0 immediately; no done.
  - A new add 0x0F0F+0x00F1 after release gives 0x1000, carry_out=0.
- Hold start=1 for 20 cycles with fixed operands 0x0001+0x0001 → done pulses every 6 cycles, each with sum=0x0002.
